// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the dmem_responder slice
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
  localparam logic [BE_W-1:0] BE_ALL = 4'b1111;

  localparam int WAIT_MAX = 15;

  // Smallest counter width able to hold max_wait.
  function automatic int wait_cnt_width(input int max_wait);
    int w;
    w = 1;
    while ((1 << w) <= max_wait) w++;
    return w;
  endfunction

  localparam int CNT_W = wait_cnt_width(WAIT_MAX);

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port word storage with byte-lane writes
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [WORD_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Byte-lane write; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read is combinational so the responder can register it on the access edge.
  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-state data-memory target; DMEM_ADDR_CHECK_EN enables address errors
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_t state, state_next;
  logic [CNT_W-1:0] cnt;
  logic accept, enter_resp;

  logic              lat_write;
  logic [ADDR_W-1:0] lat_addr;
  logic [WORD_W-1:0] lat_wdata;
  logic [BE_W-1:0]   lat_be;

  logic              acc_write, acc_err, mem_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [WORD_W-1:0] acc_wdata, mem_rdata;
  logic [BE_W-1:0]   acc_be;
  logic [IDX_W-1:0]  acc_idx;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake decode; req_ready depends on state only.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Wait counter: loaded on accept, counts down and parks at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept && WAIT_CYCLES != 0) begin
      cnt <= CNT_W'(WAIT_CYCLES - 1);
    end else if (state == WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Request capture on the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
    end else if (accept) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_be    <= req_be;
    end
  end

  // With zero wait states the access happens on the accept edge itself,
  // before the latches are loaded, so the live request is used from IDLE.
  assign acc_write = (state == IDLE) ? req_write : lat_write;
  assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
  assign acc_be    = (state == IDLE) ? req_be    : lat_be;
  assign acc_idx   = acc_addr[IDX_W+1:2];

`ifdef DMEM_ADDR_CHECK_EN
  assign acc_err = (|acc_addr[1:0]) || (|acc_addr[ADDR_W-1:IDX_W+2]);
`else
  logic unused_addr_bits;
  assign acc_err          = 1'b0;
  assign unused_addr_bits = ^{acc_addr[1:0], acc_addr[ADDR_W-1:IDX_W+2]};
`endif

  assign mem_we = enter_resp && acc_write && !acc_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .idx   (acc_idx),
    .wdata (acc_wdata),
    .be    (acc_be),
    .rdata (mem_rdata)
  );

  // Response registers: loaded on RESP entry, held until the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= (acc_write || acc_err) ? '0 : mem_rdata;
      rsp_err   <= acc_err;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - self-checking bench for dmem_responder
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_write, rsp_ready, zw;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        rdy_a, vld_a, err_a, rdy_z, vld_z, err_z;
  logic [31:0] rd_a, rd_z;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid & ~zw), .req_ready(rdy_a),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(vld_a), .rsp_ready(rsp_ready), .rsp_rdata(rd_a), .rsp_err(err_a)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0), .ADDR_W(32)) dut_zw (
    .clk(clk), .rst(rst), .req_valid(req_valid & zw), .req_ready(rdy_z),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(vld_z), .rsp_ready(rsp_ready), .rsp_rdata(rd_z), .rsp_err(err_z)
  );

  wire        o_rdy = zw ? rdy_z : rdy_a;
  wire        o_vld = zw ? vld_z : vld_a;
  wire        o_err = zw ? err_z : err_a;
  wire [31:0] o_rd  = zw ? rd_z  : rd_a;

  logic [31:0] mem_a [256];
  logic [31:0] mem_z [256];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
`ifdef DMEM_ADDR_CHECK_EN
    return (a % 4 != 0) || (a / 4 >= 256);
`else
    return 1'b0;
`endif
  endfunction

  // One complete transaction; model updated first, DUT compared against it.
  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input int hold, output logic [31:0] got);
    int k, idx, lat;
    bit bad;
    logic [31:0] word, exp_rd;
    bad    = addr_bad(a);
    idx    = (a / 4) % 256;
    word   = zw ? mem_z[idx] : mem_a[idx];
    exp_rd = 32'h0;
    lat    = zw ? 0 : 2;
    if (w && !bad) begin
      for (int i = 0; i < 4; i++) if (be[i]) word[8*i +: 8] = wd[8*i +: 8];
      if (zw) mem_z[idx] = word; else mem_a[idx] = word;
    end else if (!w && !bad) begin
      exp_rd = word;
    end
    check("req_ready_idle", {31'b0, o_rdy}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
    k = 0;
    while (!o_vld && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("latency", k, lat);
    check("rsp_valid", {31'b0, o_vld}, 32'd1);
    check("rsp_rdata", o_rd, exp_rd);
    check("rsp_err", {31'b0, o_err}, {31'b0, bad});
    check("req_ready_busy", {31'b0, o_rdy}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'b0, o_vld}, 32'd1);
      check("hold_rdata", o_rd, exp_rd);
      check("hold_ready", {31'b0, o_rdy}, 32'd0);
    end
    got = o_rd;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("rsp_valid_clr", {31'b0, o_vld}, 32'd0);
    check("req_ready_back", {31'b0, o_rdy}, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int idx;
    logic [31:0] a;
    rst = 1'b1; zw = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_be = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, vld_a}, 32'd0);
    check("rst_rdata", rd_a, 32'd0);
    check("rst_err", {31'b0, err_a}, 32'd0);
    check("rst_valid_zw", {31'b0, vld_z}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", {31'b0, rdy_a}, 32'd1);
    check("rst_ready_zw", {31'b0, rdy_z}, 32'd1);
    @(posedge clk); #1;

    // Store then load, then a single-lane store.
    txn(1, 32'h10, 32'hDEADBEEF, BE_ALL, 0, got);
    check("store_rdata_zero", got, 32'h0);
    txn(0, 32'h10, 32'h0, 4'b0000, 0, got);
    check("load_deadbeef", got, 32'hDEADBEEF);
    txn(1, 32'h10, 32'h0000AA00, 4'b0010, 0, got);
    txn(0, 32'h10, 32'h0, BE_ALL, 0, got);
    check("load_lane", got, 32'hDEADAAEF);

    // Backpressure on the response channel.
    txn(0, 32'h10, 32'h0, 4'b0000, 5, got);
    check("load_backpressure", got, 32'hDEADAAEF);

    // Store with no lanes enabled.
    txn(1, 32'h10, 32'h12345678, 4'b0000, 0, got);
    txn(0, 32'h10, 32'h0, BE_ALL, 0, got);
    check("be_none_unchanged", got, 32'hDEADAAEF);

    // Misaligned and out-of-range addresses.
    txn(1, 32'h0, 32'h0BADF00D, BE_ALL, 0, got);
    txn(1, 32'h13, 32'h11111111, BE_ALL, 0, got);
    txn(1, 32'h400, 32'h22222222, BE_ALL, 0, got);
    txn(0, 32'h10, 32'h0, BE_ALL, 0, got);
    txn(0, 32'h0, 32'h0, BE_ALL, 0, got);
`ifdef DMEM_ADDR_CHECK_EN
    check("oob_word0_kept", got, 32'h0BADF00D);
`else
    check("wrap_word0", got, 32'h22222222);
`endif

    // Reset while a store is waiting.
    txn(1, 32'h20, 32'hCAFEF00D, BE_ALL, 0, got);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = BE_ALL;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'b0, vld_a}, 32'd0);
    check("midrst_rdata", rd_a, 32'd0);
    check("midrst_err", {31'b0, err_a}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_ready", {31'b0, rdy_a}, 32'd1);
    @(posedge clk); #1;
    txn(0, 32'h20, 32'h0, BE_ALL, 0, got);
    check("midrst_store_dropped", got, 32'hCAFEF00D);

    // Randomised traffic over a small initialised window plus aliases.
    for (int i = 0; i < 16; i++) txn(1, i * 4, $urandom, BE_ALL, 0, got);
    for (int n = 0; n < 40; n++) begin
      idx = $urandom_range(0, 15);
      a = idx * 4;
      if ($urandom_range(0, 3) == 0) a = a + $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) a = a + 32'h400 * $urandom_range(1, 4);
      txn($urandom_range(0, 1), a, $urandom, 4'($urandom), $urandom_range(0, 2), got);
    end

    // Zero-wait instance.
    zw = 1'b1;
    #1;
    txn(1, 32'h10, 32'h5A5AC3C3, BE_ALL, 0, got);
    txn(0, 32'h10, 32'h0, BE_ALL, 1, got);
    check("zw_load", got, 32'h5A5AC3C3);
    for (int n = 0; n < 6; n++) begin
      a = $urandom_range(0, 3) * 4;
      txn($urandom_range(0, 1), a, $urandom, BE_ALL, 0, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
